// File: rtl/pipeline_sequencer.sv
// Run-control and hazard scheduler for a 5-stage MIPS pipeline: drives PC and
// pipeline-latch write enables and flushes, and counts executed (advance) cycles.
module pipeline_sequencer #(
  parameter int W     = 5,
  parameter int DRAIN = 4,
  parameter int CW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          mode_step,
  input  logic          step_pulse,
  input  logic          halt_detected,
  input  logic          branch_taken,
  input  logic          ex_MemRead,
  input  logic [W-1:0]  ex_rt,
  input  logic [W-1:0]  id_rs,
  input  logic [W-1:0]  id_rt,
  output logic          pc_en,
  output logic          if_id_en,
  output logic          id_ex_en,
  output logic          ex_mem_en,
  output logic          mem_wb_en,
  output logic          if_id_flush,
  output logic          id_ex_flush,
  output logic [2:0]    state,
  output logic          halted,
  output logic [CW-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'b000,
    S_RUN       = 3'b001,
    S_STEP_WAIT = 3'b010,
    S_STEP_EXEC = 3'b011,
    S_DRAIN     = 3'b100,
    S_HALTED    = 3'b101
  } state_t;

  localparam logic [3:0]    DRAIN_LOAD = 4'(DRAIN - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  state_t      state_q, state_d;
  logic [3:0]  drain_cnt;
  logic        step_q;
  logic        advance;
  logic        load_use;
  logic        step_rise;

  assign load_use  = ex_MemRead && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  assign step_rise = step_pulse & ~step_q;

  assign state  = state_q;
  assign halted = (state_q == S_HALTED);

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_d     = state_q;
    advance     = 1'b0;
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    id_ex_en    = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = mode_step ? S_STEP_WAIT : S_RUN;
      end

      S_RUN, S_STEP_EXEC: begin
        advance   = 1'b1;
        pc_en     = 1'b1;
        if_id_en  = 1'b1;
        id_ex_en  = 1'b1;
        ex_mem_en = 1'b1;
        mem_wb_en = 1'b1;
        // A taken branch squashes the IF/ID instruction, so halt and load-use lose.
        if (branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (halt_detected) begin
          pc_en       = 1'b0;
          if_id_flush = 1'b1;
        end else if (load_use) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end

        if (!branch_taken && halt_detected) state_d = S_DRAIN;
        else if (state_q == S_STEP_EXEC)    state_d = S_STEP_WAIT;
        else if (mode_step)                 state_d = S_STEP_WAIT;
        else                                state_d = S_RUN;
      end

      S_STEP_WAIT: begin
        if (!mode_step)     state_d = S_RUN;
        else if (step_rise) state_d = S_STEP_EXEC;
      end

      S_DRAIN: begin
        advance     = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b1;
        if (drain_cnt == 4'd0) state_d = S_HALTED;
      end

      S_HALTED: state_d = S_HALTED;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      drain_cnt   <= 4'd0;
      step_q      <= 1'b0;
      cycle_count <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_pulse;

      if (state_d == S_DRAIN && state_q != S_DRAIN) drain_cnt <= DRAIN_LOAD;
      else if (state_q == S_DRAIN && drain_cnt != 4'd0) drain_cnt <= drain_cnt - 4'd1;

      // Saturate rather than wrap so the debugger never sees a small count after a long run.
      if (advance && cycle_count != '1) cycle_count <= cycle_count + CNT_ONE;
    end
  end

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
- Central run-control and hazard scheduler for the 5-stage MIPS pipeline.
- Drives the write enables of the PC and the four pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB), plus the IF/ID and ID/EX flushes.
- Supports free-run and single-step execution, inserts load-use bubbles, squashes on taken branches, and drains the pipeline on HALT.
- Counts executed cycles for the debug unit.

Parameters:
- W, 5, register-address width of the rs/rt compare inputs.
- DRAIN, 4, number of bubble cycles injected after HALT before entering HALTED; legal range 1..15.
- CW, 32, cycle-counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level; leaves IDLE.
- mode_step  in  1  1 = single-step mode, 0 = free-run.
- step_pulse  in  1  step request; only its rising edge counts.
- halt_detected  in  1  HALT opcode present in IF/ID.
- branch_taken  in  1  taken branch resolved in EX.
- ex_MemRead  in  1  the instruction in ID/EX is a load.
- ex_rt  in  W  destination rt of the instruction in ID/EX.
- id_rs  in  W  rs of the instruction in IF/ID.
- id_rt  in  W  rt of the instruction in IF/ID.
- pc_en  out  1  PC write enable.
- if_id_en  out  1  IF/ID write enable.
- id_ex_en  out  1  ID/EX write enable.
- ex_mem_en  out  1  EX/MEM write enable.
- mem_wb_en  out  1  MEM/WB write enable.
- if_id_flush  out  1  zero IF/ID contents on the next write.
- id_ex_flush  out  1  zero ID/EX control signals on the next write.
- state  out  3  current FSM state encoding.
- halted  out  1  high in HALTED.
- cycle_count  out  CW  number of advance cycles executed.

Behaviour:
- Reset (reset=0, asynchronous, effective at any time including mid-step or mid-drain):
  - state=IDLE; all enables and flushes 0; halted=0; cycle_count=0; drain counter=0; step edge register=0.
- State encodings: IDLE=000, RUN=001, STEP_WAIT=010, STEP_EXEC=011, DRAIN=100, HALTED=101. Unused codes return to IDLE.
- Transitions:
  - IDLE: if start=1, go to STEP_WAIT when mode_step=1, else RUN.
  - RUN: go to DRAIN on an accepted halt. Otherwise go to STEP_WAIT if mode_step=1; the current cycle still advances.
  - STEP_WAIT: go to RUN if mode_step=0. Go to STEP_EXEC on step_rise = step_pulse & ~step_q, where step_q is step_pulse registered. A held step_pulse yields exactly one step.
  - STEP_EXEC: exactly one cycle. Go to DRAIN on an accepted halt, else back to STEP_WAIT.
  - DRAIN: drain counter is loaded with DRAIN-1 on entry and decrements each cycle. Go to HALTED when it reaches 0, so DRAIN occupies exactly DRAIN cycles. The drain completes even if mode_step=1.
  - HALTED: sticky until reset; start is ignored.
- Advance cycles are those spent in RUN, STEP_EXEC or DRAIN. Outputs are combinational from state and hazard inputs.
- Non-advance states (IDLE, STEP_WAIT, HALTED): every enable and flush is 0.
- Advance cycle, base case: all five enables 1, flushes 0.
- Priority in RUN and STEP_EXEC, highest first:
  1. branch_taken=1: if_id_flush=1, id_ex_flush=1, all enables 1. Any simultaneous halt_detected or load-use is ignored, because that instruction is squashed.
  2. halt_detected=1 (accepted halt): pc_en=0, if_id_flush=1, other enables 1; next state is DRAIN.
  3. Load-use, defined as ex_MemRead & (ex_rt!=0) & (ex_rt==id_rs | ex_rt==id_rt): pc_en=0, if_id_en=0, id_ex_flush=1; id_ex_en, ex_mem_en and mem_wb_en stay 1.
- DRAIN: pc_en=0, if_id_en=1, if_id_flush=1, all other enables 1; branch, halt and hazard inputs are ignored.
- cycle_count: +1 on every advance cycle; saturates at all ones (no wrap).

Test Plan:
- Reset then start=1, mode_step=0, 10 idle cycles with no hazards -> state 000->001, all enables 1, cycle_count=10; drive reset=0 mid-run -> all outputs 0 and state=000 immediately, without waiting for a clock edge.
- RUN with ex_MemRead=1, ex_rt=5, id_rs=5 for one cycle -> pc_en=0, if_id_en=0, id_ex_flush=1. Repeat with ex_rt=0 -> no stall. Repeat with id_rt=5 -> stall.
- RUN with branch_taken=1, halt_detected=1 and load-use all asserted together -> both flushes 1, all enables 1, state stays 001.
- RUN with halt_detected=1 and DRAIN=4 -> 4 cycles in state 100 with pc_en=0 and if_id_flush=1, then state 101 and halted=1; cycle_count grows by 5 (halt cycle plus 4 drain cycles), then freezes; a later start has no effect.
- mode_step=1: step_pulse held high for 6 cycles -> exactly one STEP_EXEC cycle and cycle_count +1. Three separate pulses -> +3. Lowering mode_step -> RUN the next cycle.
- CW=4: run 20 advance cycles -> cycle_count saturates at 15.
